instr_issue: RTL and testbench

Instruction sequencer that drives the ALU result-select decoder and its datapath. It fetches 16-bit instruction words over a req/ack memory handshake and encodes each word into the 3-bit sel opcode plus the RA/RB operand values read from an internal 8x16 register file. It then captures the decoded outA/outB/ZNC results and writes them back to the register file and flag register. It sits between program memory and the combinational ALU/decoder cluster.

---
 rtl/instr_issue_pkg.sv | 48 ++++
 rtl/instr_issue_regfile.sv | 50 +++++
 rtl/instr_issue.sv | 156 +++++++++++++++
 tb/tb_instr_issue.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issue_pkg.sv
// Shared definitions for the instruction sequencer: opcode values handed to
// the result-select decoder, instruction field positions, FSM states and
// small helpers describing which destinations an opcode writes back.
package instr_issue_pkg;

    // Opcode values, passed unchanged to the decoder sel input
    localparam logic [2:0] OP_XOR  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_EXCH = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    // Instruction word field positions
    localparam int unsigned OPC_HI   = 15;
    localparam int unsigned OPC_LO   = 13;
    localparam int unsigned A_HI     = 12;
    localparam int unsigned A_LO     = 10;
    localparam int unsigned B_HI     = 9;
    localparam int unsigned B_LO     = 7;
    localparam int unsigned HALT_BIT = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WB,
        HALT
    } state_t;

    // Everything except MOV writes reg[A]
    function automatic logic writes_a(input logic [2:0] opc);
        return opc != OP_MOV;
    endfunction

    // MOV and EXCH write reg[B]
    function automatic logic writes_b(input logic [2:0] opc);
        return (opc == OP_MOV) || (opc == OP_EXCH);
    endfunction

    // EXCH leaves the flag register alone
    function automatic logic writes_flags(input logic [2:0] opc);
        return opc != OP_EXCH;
    endfunction

endpackage

// File: rtl/instr_issue_regfile.sv
// 8x16 register file for the instruction sequencer.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset (clears all entries)
//   ra_idx/ra_data        asynchronous read port A
//   rb_idx/rb_data        asynchronous read port B
//   dbg_idx/dbg_data      asynchronous debug read port
//   wa_en/wa_idx/wa_data  synchronous write port A
//   wb_en/wb_idx/wb_data  synchronous write port B (wins over A on same index)
module regfile_8x16 #(
    parameter int unsigned NREG = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  ra_idx,
    output logic [15:0] ra_data,
    input  logic [2:0]  rb_idx,
    output logic [15:0] rb_data,
    input  logic [2:0]  dbg_idx,
    output logic [15:0] dbg_data,
    input  logic        wa_en,
    input  logic [2:0]  wa_idx,
    input  logic [15:0] wa_data,
    input  logic        wb_en,
    input  logic [2:0]  wb_idx,
    input  logic [15:0] wb_data
);

    logic [15:0] mem [NREG];

    assign ra_data  = mem[ra_idx];
    assign rb_data  = mem[rb_idx];
    assign dbg_data = mem[dbg_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wa_en) begin
                mem[wa_idx] <= wa_data;
            end
            // Port B is written last so it takes priority on an index collision
            if (wb_en) begin
                mem[wb_idx] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Instruction sequencer feeding the ALU result-select decoder.
// Fetches 16-bit words over a req/ack handshake, presents sel/RA/RB/flags to
// the decoder for one ISSUE cycle, captures its results and writes them back.
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   start                  1-cycle pulse, begins execution at address 0
//   busy, halted           run status
//   imem_req/addr/ack/data instruction fetch handshake
//   sel, op_ra, op_rb      decoder opcode and operands
//   znc_in                 current {Z,N,C} flags to the decoder
//   res_a, res_b, znc_res  decoder results
//   instr_cnt              retired-instruction count
//   dbg_idx/dbg_data       register-file read-back
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter int unsigned AW   = 8,
    parameter int unsigned NREG = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          halted,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_data,
    output logic [2:0]    sel,
    output logic [15:0]   op_ra,
    output logic [15:0]   op_rb,
    output logic [2:0]    znc_in,
    input  logic [15:0]   res_a,
    input  logic [15:0]   res_b,
    input  logic [2:0]    znc_res,
    output logic [15:0]   instr_cnt,
    input  logic [2:0]    dbg_idx,
    output logic [15:0]   dbg_data
);

    state_t        state;
    logic [AW-1:0] pc;
    logic [2:0]    flags;
    logic [2:0]    ir_opc;
    logic [2:0]    ir_a;
    logic [2:0]    ir_b;
    logic [15:0]   hold_a;
    logic [15:0]   hold_b;
    logic [2:0]    hold_znc;

    logic [15:0]   rf_ra;
    logic [15:0]   rf_rb;
    logic          wa_en;
    logic          wb_en;
    logic          unused_bits;

    assign imem_addr   = pc;
    assign unused_bits = ^imem_data[HALT_BIT-1:0];

    assign wa_en = (state == WB) && writes_a(ir_opc);
    assign wb_en = (state == WB) && writes_b(ir_opc);

    // Operand reads are indexed straight from the fetched word so the
    // operands can be registered on the ack edge and be valid during ISSUE.
    regfile_8x16 #(.NREG(NREG)) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .ra_idx   (imem_data[A_HI:A_LO]),
        .ra_data  (rf_ra),
        .rb_idx   (imem_data[B_HI:B_LO]),
        .rb_data  (rf_rb),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data),
        .wa_en    (wa_en),
        .wa_idx   (ir_a),
        .wa_data  (hold_a),
        .wb_en    (wb_en),
        .wb_idx   (ir_b),
        .wb_data  (hold_b)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc        <= '0;
            flags     <= '0;
            instr_cnt <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            imem_req  <= 1'b0;
            sel       <= '0;
            op_ra     <= '0;
            op_rb     <= '0;
            znc_in    <= '0;
            ir_opc    <= '0;
            ir_a      <= '0;
            ir_b      <= '0;
            hold_a    <= '0;
            hold_b    <= '0;
            hold_znc  <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state    <= FETCH;
                        pc       <= '0;
                        halted   <= 1'b0;
                        busy     <= 1'b1;
                        imem_req <= 1'b1;
                    end
                end

                FETCH: begin
                    if (imem_req && imem_ack) begin
                        imem_req <= 1'b0;
                        ir_opc   <= imem_data[OPC_HI:OPC_LO];
                        ir_a     <= imem_data[A_HI:A_LO];
                        ir_b     <= imem_data[B_HI:B_LO];
                        if (imem_data[HALT_BIT]) begin
                            // HALT does not retire: PC and count stay put
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                            sel    <= imem_data[OPC_HI:OPC_LO];
                            op_ra  <= rf_ra;
                            op_rb  <= rf_rb;
                            znc_in <= flags;
                        end
                    end
                end

                ISSUE: begin
                    hold_a   <= res_a;
                    hold_b   <= res_b;
                    hold_znc <= znc_res;
                    state    <= WB;
                end

                WB: begin
                    if (writes_flags(ir_opc)) begin
                        flags <= hold_znc;
                    end
                    pc        <= pc + AW'(1);
                    instr_cnt <= instr_cnt + 16'd1;
                    imem_req  <= 1'b1;
                    state     <= FETCH;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;
    import instr_issue_pkg::*;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          halted;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [15:0]   imem_data = '0;
    logic [2:0]    sel;
    logic [15:0]   op_ra;
    logic [15:0]   op_rb;
    logic [2:0]    znc_in;
    logic [15:0]   res_a;
    logic [15:0]   res_b;
    logic [2:0]    znc_res;
    logic [15:0]   instr_cnt;
    logic [2:0]    dbg_idx = '0;
    logic [15:0]   dbg_data;

    // Decoder stand-in; overrides let directed steps inject arbitrary results
    logic          ovr_en = 1'b0;
    logic [15:0]   ovr_a = '0;
    logic [15:0]   ovr_b = '0;
    logic [2:0]    ovr_znc = '0;
    logic [34:0]   dec;

    // Reference architectural state
    logic [15:0]   mreg [8];
    logic [2:0]    mflags;
    logic [15:0]   mcnt;
    logic [AW-1:0] mpc;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] val;
    } exp_t;
    exp_t sbq[$];

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    always #10 clk = ~clk;

    instr_issue #(.AW(AW), .NREG(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .halted    (halted),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .sel       (sel),
        .op_ra     (op_ra),
        .op_rb     (op_rb),
        .znc_in    (znc_in),
        .res_a     (res_a),
        .res_b     (res_b),
        .znc_res   (znc_res),
        .instr_cnt (instr_cnt),
        .dbg_idx   (dbg_idx),
        .dbg_data  (dbg_data)
    );

    function automatic logic [34:0] alu(input logic [2:0] s, input logic [15:0] a,
                                        input logic [15:0] b, input logic [2:0] zin);
        logic [16:0] w;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        c;
        logic [2:0]  z;
        rb = b;
        c  = 1'b0;
        w  = '0;
        case (s)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; ra = w[15:0]; c = w[16]; end
            OP_SUB: begin w = {1'b0, a} - {1'b0, b}; ra = w[15:0]; c = w[16]; end
            OP_OR:  ra = a | b;
            OP_AND: ra = a & b;
            OP_XOR: ra = a ^ b;
            OP_SHR: begin ra = a >> 1; c = a[0]; end
            OP_MOV: begin ra = a; rb = a; end
            default: begin ra = b; rb = a; end
        endcase
        if (s == OP_MOV || s == OP_EXCH) z = zin;
        else z = {ra == 16'd0, ra[15], c};
        return {ra, rb, z};
    endfunction

    always_comb begin
        dec = alu(sel, op_ra, op_rb, znc_in);
        if (ovr_en) dec = {ovr_a, ovr_b, ovr_znc};
    end
    assign res_a   = dec[34:19];
    assign res_b   = dec[18:3];
    assign znc_res = dec[2:0];

    function automatic logic [15:0] mk(input logic [2:0] o, input logic [2:0] a,
                                       input logic [2:0] b, input logic h, input logic [5:0] rsv);
        return {o, a, b, h, rsv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        mflags = '0;
        mcnt   = '0;
        mpc    = '0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_idx = 3'(i);
            #1;
            chk(tag, dbg_data, mreg[i]);
        end
    endtask

    task automatic run_instr(input logic [15:0] w, input int unsigned dly, input bit poke_start);
        logic [2:0]  opc;
        logic [2:0]  ia;
        logic [2:0]  ib;
        logic [2:0]  sel_prev;
        logic [34:0] r;
        exp_t        e;
        int unsigned t;
        opc = w[15:13];
        ia  = w[12:10];
        ib  = w[9:7];
        t   = 0;
        while (imem_req !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        chk("req_wait", imem_req, 1);
        if (imem_req !== 1'b1) return;
        chk("fetch_addr", imem_addr, mpc);
        sel_prev = sel;
        for (int i = 0; i < dly; i++) begin
            if (poke_start && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
            chk("hold_req", imem_req, 1);
            chk("hold_addr", imem_addr, mpc);
            chk("hold_sel", sel, sel_prev);
            chk("hold_busy", busy, 1);
        end
        imem_data = w;
        imem_ack  = 1'b1;
        tick();
        imem_ack  = 1'b0;
        imem_data = 16'hFFFF;
        if (w[6]) begin
            chk("halt_halted", halted, 1);
            chk("halt_busy", busy, 0);
            chk("halt_req", imem_req, 0);
            chk("halt_addr", imem_addr, mpc);
            chk("halt_cnt", instr_cnt, mcnt);
            return;
        end
        chk("issue_sel", sel, opc);
        chk("issue_ra", op_ra, mreg[ia]);
        chk("issue_rb", op_rb, mreg[ib]);
        chk("issue_znc", znc_in, mflags);
        chk("issue_req", imem_req, 0);
        r = ovr_en ? {ovr_a, ovr_b, ovr_znc} : alu(opc, mreg[ia], mreg[ib], mflags);
        if (opc != OP_MOV) mreg[ia] = r[34:19];
        if (opc == OP_MOV || opc == OP_EXCH) mreg[ib] = r[18:3];
        if (opc != OP_EXCH) mflags = r[2:0];
        mcnt = mcnt + 16'd1;
        mpc  = mpc + AW'(1);
        sbq.push_back('{idx: ia, val: mreg[ia]});
        sbq.push_back('{idx: ib, val: mreg[ib]});
        tick();
        tick();
        chk("next_req", imem_req, 1);
        chk("retire_cnt", instr_cnt, mcnt);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            dbg_idx = e.idx;
            #1;
            chk("wb_reg", dbg_data, e.val);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_ovr(input logic [15:0] a, input logic [15:0] b, input logic [2:0] z);
        ovr_en  = 1'b1;
        ovr_a   = a;
        ovr_b   = b;
        ovr_znc = z;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_sel", sel, 0);
        chk("rst_ra", op_ra, 0);
        chk("rst_rb", op_rb, 0);
        chk("rst_znc", znc_in, 0);
        chk("rst_cnt", instr_cnt, 0);
        check_all("rst_reg");

        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_req", imem_req, 1);

        // Preload reg1=5, reg2=3 then ADD 1,2
        set_ovr(16'h0000, 16'h0005, 3'b000);
        run_instr(mk(OP_MOV, 3'd0, 3'd1, 1'b0, 6'h0), 0, 1'b0);
        set_ovr(16'h0000, 16'h0003, 3'b000);
        run_instr(mk(OP_MOV, 3'd0, 3'd2, 1'b0, 6'h0), 0, 1'b0);
        ovr_en = 1'b0;
        run_instr(mk(OP_ADD, 3'd1, 3'd2, 1'b0, 6'h0), 0, 1'b0);
        dbg_idx = 3'd1;
        #1;
        chk("add_reg1", dbg_data, 16'h0008);

        // EXCH with distinct indices, then A==B with B-port priority
        set_ovr(16'h0000, 16'h1111, 3'b000);
        run_instr(mk(OP_MOV, 3'd0, 3'd3, 1'b0, 6'h0), 0, 1'b0);
        set_ovr(16'h0000, 16'h2222, 3'b101);
        run_instr(mk(OP_MOV, 3'd0, 3'd4, 1'b0, 6'h0), 0, 1'b0);
        ovr_en = 1'b0;
        run_instr(mk(OP_EXCH, 3'd3, 3'd4, 1'b0, 6'h0), 0, 1'b0);
        set_ovr(16'hAAAA, 16'hBBBB, 3'b010);
        run_instr(mk(OP_EXCH, 3'd5, 3'd5, 1'b0, 6'h0), 0, 1'b0);
        ovr_en = 1'b0;
        dbg_idx = 3'd5;
        #1;
        chk("exch_same", dbg_data, 16'hBBBB);

        // Ack delayed 4 cycles with a start pulse mid-wait
        run_instr(mk(OP_SUB, 3'd1, 3'd2, 1'b0, 6'h0), 4, 1'b1);
        run_instr(mk(OP_SUB, 3'd2, 3'd1, 1'b0, 6'h15), 0, 1'b0);
        check_all("delay_regs");

        // Reset while fetching with req high
        chk("pre_rst_req", imem_req, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        chk("midrst_req", imem_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", instr_cnt, 0);
        chk("midrst_addr", imem_addr, 0);
        chk("midrst_sel", sel, 0);
        check_all("midrst_reg");

        // Three instructions then HALT at address 3
        pulse_start();
        set_ovr(16'h0000, 16'h8001, 3'b000);
        run_instr(mk(OP_MOV, 3'd0, 3'd6, 1'b0, 6'h0), 0, 1'b0);
        ovr_en = 1'b0;
        run_instr(mk(OP_ADD, 3'd6, 3'd6, 1'b0, 6'h0), 0, 1'b0);
        run_instr(mk(OP_SHR, 3'd6, 3'd0, 1'b0, 6'h2A), 0, 1'b0);
        run_instr(mk(OP_ADD, 3'd6, 3'd6, 1'b1, 6'h0), 0, 1'b0);
        chk("halt_cnt3", instr_cnt, 16'd3);
        chk("halt_pc3", imem_addr, 3);
        check_all("halt_regs");
        imem_data = mk(OP_ADD, 3'd6, 3'd6, 1'b0, 6'h0);
        imem_ack  = 1'b1;
        tick();
        imem_ack  = 1'b0;
        tick();
        chk("stray_ack_halted", halted, 1);
        chk("stray_ack_req", imem_req, 0);
        chk("stray_ack_cnt", instr_cnt, 16'd3);
        check_all("stray_ack_regs");
        pulse_start();
        mpc = '0;
        chk("restart_busy", busy, 1);
        chk("restart_halted", halted, 0);
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 0);

        // 256 instructions from a clean reset: PC wraps back to 0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            logic [2:0] o;
            if (i % 8 == 0) begin
                set_ovr(16'($urandom), 16'($urandom), 3'($urandom));
                o = OP_MOV;
            end else begin
                o = 3'(i);
            end
            run_instr(mk(o, 3'(i * 3), 3'(i * 5 + 1), 1'b0, 6'h0), 0, 1'b0);
            ovr_en = 1'b0;
        end
        chk("wrap_addr", imem_addr, 0);
        chk("wrap_cnt", instr_cnt, 16'd256);
        check_all("wrap_regs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
